// File: rtl/render_fb_pkg.sv
// Shared constants, FSM state type and pixel packing for the frame-buffer writer
// and the display-side address logic.
package render_fb_pkg;

    localparam int DEF_START_X    = 390;
    localparam int DEF_START_Y    = 390;
    localparam int DEF_END_X      = 634;
    localparam int DEF_END_Y      = 765;
    localparam int DEF_ADDR_WIDTH = 17;

    localparam int REGION_W = DEF_END_X - DEF_START_X;
    localparam int REGION_H = DEF_END_Y - DEF_START_Y;
    localparam int FB_DEPTH = REGION_W * REGION_H;

    typedef enum logic {
        FILL      = 1'b0,
        WAIT_SWAP = 1'b1
    } fb_state_t;

    // Keep the top nibble of each channel: {R[7:4],G[7:4],B[7:4]}.
    function automatic logic [11:0] pack_rgb444(input logic [23:0] rgb);
        return {rgb[23:20], rgb[15:12], rgb[7:4]};
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Window membership test and window-relative linear address for a screen pixel.
// Purely combinational so both the write and read sides can share it.
module fb_addr_calc
    import render_fb_pkg::*;
#(
    parameter int START_X    = DEF_START_X,
    parameter int START_Y    = DEF_START_Y,
    parameter int END_X      = DEF_END_X,
    parameter int END_Y      = DEF_END_Y,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic [10:0]           hcount_i,
    input  logic [9:0]            vcount_i,
    output logic                  in_window_o,
    output logic [ADDR_WIDTH-1:0] addr_o
);

    localparam int              W  = END_X - START_X;
    localparam logic [10:0]     SX = 11'(START_X);
    localparam logic [10:0]     EX = 11'(END_X);
    localparam logic [9:0]      SY = 10'(START_Y);
    localparam logic [9:0]      EY = 10'(END_Y);

    logic [ADDR_WIDTH-1:0] col;
    logic [ADDR_WIDTH-1:0] row;

    always_comb begin
        in_window_o = (hcount_i >= SX) && (hcount_i < EX) &&
                      (vcount_i >= SY) && (vcount_i < EY);
        // Offsets are only meaningful inside the window; outside they wrap harmlessly.
        col    = ADDR_WIDTH'(hcount_i - SX);
        row    = ADDR_WIDTH'(vcount_i - SY);
        addr_o = col + row * ADDR_WIDTH'(W);
    end

endmodule

// File: rtl/render_fb_writer.sv
// AXI-stream pixel sink that writes the 3D window into a double-buffered
// RGB444 frame buffer and swaps banks on the display's new-frame pulse.
module render_fb_writer
    import render_fb_pkg::*;
#(
    parameter int START_X    = DEF_START_X,
    parameter int START_Y    = DEF_START_Y,
    parameter int END_X      = DEF_END_X,
    parameter int END_Y      = DEF_END_Y,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  aclk,
    input  logic                  rst_in,
    input  logic [23:0]           pixel_axis_tdata,
    input  logic                  pixel_axis_tvalid,
    output logic                  pixel_axis_tready,
    input  logic [10:0]           hcount_in,
    input  logic [9:0]            vcount_in,
    input  logic                  nf_in,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [11:0]           wr_data,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic                  rd_bank,
    output logic                  frame_done,
    output logic                  err_oob,
    output logic                  err_short
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int N     = (END_X - START_X) * (END_Y - START_Y);

    fb_state_t             state_q, state_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]           wr_data_q, wr_data_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_oob_q, err_oob_d;
    logic                  err_short_q, err_short_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  handshake;
    logic                  in_window;
    logic                  last_px;
    logic [ADDR_WIDTH-1:0] pix_addr;

    fb_addr_calc #(
        .START_X   (START_X),
        .START_Y   (START_Y),
        .END_X     (END_X),
        .END_Y     (END_Y),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr (
        .hcount_i   (hcount_in),
        .vcount_i   (vcount_in),
        .in_window_o(in_window),
        .addr_o     (pix_addr)
    );

    assign pixel_axis_tready = (state_q == FILL) && !rst_in;
    assign handshake         = pixel_axis_tvalid && pixel_axis_tready;
    assign last_px           = (hcount_in == 11'(END_X - 1)) && (vcount_in == 10'(END_Y - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        frame_done_d = 1'b0;
        err_oob_d    = err_oob_q;
        err_short_d  = err_short_q;
        cnt_d        = cnt_q;

        case (state_q)
            FILL: begin
                if (handshake && in_window) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_addr;
                    wr_data_d = pack_rgb444(pixel_axis_tdata);
                    cnt_d     = (cnt_q == CNT_W'(N)) ? cnt_q : cnt_q + 1'b1;
                    if (last_px) begin
                        state_d = WAIT_SWAP;
                        cnt_d   = '0;
                        // cnt_q already excludes this pixel, so compare against N-1.
                        if (cnt_q < CNT_W'(N - 1)) err_short_d = 1'b1;
                    end
                end else if (handshake) begin
                    err_oob_d = 1'b1;
                end
            end
            WAIT_SWAP: begin
                if (nf_in) begin
                    wr_bank_d    = ~wr_bank_q;
                    rd_bank_d    = wr_bank_q;
                    frame_done_d = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= FILL;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            frame_done_q <= 1'b0;
            err_oob_q    <= 1'b0;
            err_short_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            frame_done_q <= frame_done_d;
            err_oob_q    <= err_oob_d;
            err_short_q  <= err_short_d;
            cnt_q        <= cnt_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_bank    = wr_bank_q;
    assign rd_bank    = rd_bank_q;
    assign frame_done = frame_done_q;
    assign err_oob    = err_oob_q;
    assign err_short  = err_short_q;

endmodule

// File: tb/tb_render_fb_writer.sv
// Scoreboard bench for render_fb_writer: expected writes are queued at the
// handshake and matched against wr_* on the falling edge.
module tb_render_fb_writer;

    localparam int SX = 390;
    localparam int SY = 390;
    localparam int EX = 634;
    localparam int EY = 765;
    localparam int W  = EX - SX;
    localparam int BUDGET = 2000;

    logic        aclk = 1'b0;
    logic        rst_in;
    logic [23:0] pixel_axis_tdata;
    logic        pixel_axis_tvalid;
    logic        pixel_axis_tready;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        nf_in;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_en;
    logic        wr_bank;
    logic        rd_bank;
    logic        frame_done;
    logic        err_oob;
    logic        err_short;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic        exp_bank;
    logic [29:0] exp_q[$];

    always #5 aclk = ~aclk;

    render_fb_writer dut (
        .aclk             (aclk),
        .rst_in           (rst_in),
        .pixel_axis_tdata (pixel_axis_tdata),
        .pixel_axis_tvalid(pixel_axis_tvalid),
        .pixel_axis_tready(pixel_axis_tready),
        .hcount_in        (hcount_in),
        .vcount_in        (vcount_in),
        .nf_in            (nf_in),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .wr_en            (wr_en),
        .wr_bank          (wr_bank),
        .rd_bank          (rd_bank),
        .frame_done       (frame_done),
        .err_oob          (err_oob),
        .err_short        (err_short)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
            else check("wr", {2'b0, wr_bank, wr_addr, wr_data}, {2'b0, exp_q.pop_front()});
        end
    end

    // Called just after a falling edge; returns just after the falling edge that follows the accept.
    task automatic send_pixel(input int h, input int v, input logic [23:0] d, input logic nf);
        int waited = 0;
        pixel_axis_tvalid = 1'b1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        pixel_axis_tdata = d;
        nf_in = nf;
        while (!pixel_axis_tready && waited < BUDGET) begin
            @(negedge aclk);
            waited++;
        end
        if (!pixel_axis_tready) begin
            check("tready_timeout", 32'd0, 32'd1);
        end else begin
            if (h >= SX && h < EX && v >= SY && v < EY)
                exp_q.push_back({exp_bank, 17'((h - SX) + (v - SY) * W), d[23:20], d[15:12], d[7:4]});
            @(negedge aclk);
        end
        pixel_axis_tvalid = 1'b0;
        nf_in = 1'b0;
    endtask

    task automatic pulse_nf();
        nf_in = 1'b1;
        @(negedge aclk);
        nf_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        pixel_axis_tvalid = 1'b0;
        nf_in = 1'b0;
        repeat (2) @(negedge aclk);
        check("queue_empty_at_reset", exp_q.size(), 0);
        exp_q.delete();
        exp_bank = 1'b0;
        rst_in = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        int stall_bad;
        rst_in = 1'b1;
        pixel_axis_tvalid = 1'b0;
        pixel_axis_tdata = '0;
        hcount_in = '0;
        vcount_in = '0;
        nf_in = 1'b0;
        exp_bank = 1'b0;
        #1;
        check("rst_tready", pixel_axis_tready, 0);
        check("rst_outs", {wr_en, wr_bank, rd_bank, frame_done, err_oob, err_short}, 6'b001000);
        check("rst_addr_data", {wr_addr, wr_data}, 0);
        do_reset();
        check("tready_after_rst", pixel_axis_tready, 1);

        // First pixel at window origin.
        send_pixel(390, 390, 24'hF0A05C, 1'b0);
        check("first_wr_en", wr_en, 1);
        check("first_addr", wr_addr, 0);
        check("first_data", wr_data, 12'hFA5);
        check("first_bank", wr_bank, 0);
        @(negedge aclk);
        check("first_wr_en_drop", wr_en, 0);

        send_pixel(633, 400, 24'h123456, 1'b0);
        check("right_edge_addr", wr_addr, 2683);
        send_pixel(389, 400, 24'hFFFFFF, 1'b0);
        check("oob_no_wr", wr_en, 0);
        check("oob_flag", err_oob, 1);
        repeat (5) @(negedge aclk);
        check("oob_sticky", err_oob, 1);

        // Full raster into bank 0.
        do_reset();
        for (int v = SY; v < EY; v++)
            for (int h = SX; h < EX; h++)
                send_pixel(h, v, 24'($urandom), 1'b0);
        check("raster_tready_low", pixel_axis_tready, 0);
        check("raster_last_addr", {wr_en, wr_addr}, {1'b1, 17'd91499});
        repeat (19) @(negedge aclk);
        check("raster_no_early_swap", {wr_bank, rd_bank}, 2'b01);
        pulse_nf();
        exp_bank = 1'b1;
        check("swap_banks", {wr_bank, rd_bank}, 2'b10);
        check("swap_frame_done", frame_done, 1);
        check("swap_tready", pixel_axis_tready, 1);
        check("raster_err_short", err_short, 0);
        @(negedge aclk);
        check("frame_done_one_cycle", frame_done, 0);

        // A lone last pixel is a short frame.
        do_reset();
        send_pixel(633, 764, 24'hABCDEF, 1'b0);
        check("short_tready_low", pixel_axis_tready, 0);
        pulse_nf();
        exp_bank = 1'b1;
        check("short_err", err_short, 1);
        check("short_swap", {wr_bank, rd_bank}, 2'b10);

        // nf during FILL, then nf coincident with the last accept: neither swaps.
        pulse_nf();
        check("nf_in_fill", {wr_bank, rd_bank, frame_done}, 3'b100);
        send_pixel(633, 764, 24'h0F0F0F, 1'b1);
        repeat (3) @(negedge aclk);
        check("nf_same_cycle", {wr_bank, rd_bank, frame_done, pixel_axis_tready}, 4'b1000);
        pulse_nf();
        exp_bank = 1'b0;
        check("nf_next_swap", {wr_bank, rd_bank, frame_done}, 3'b011);

        // Stalled in WAIT_SWAP with tvalid held.
        send_pixel(633, 764, 24'h777777, 1'b0);
        pixel_axis_tvalid = 1'b1;
        hcount_in = 11'd400;
        vcount_in = 10'd400;
        stall_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge aclk);
            if (pixel_axis_tready !== 1'b0 || wr_en !== 1'b0) stall_bad++;
        end
        pixel_axis_tvalid = 1'b0;
        check("stall_quiet", stall_bad, 0);

        // Asynchronous reset mid-frame, while a write is on the bus.
        pulse_nf();
        exp_bank = 1'b1;
        send_pixel(391, 392, 24'h89ABCD, 1'b0);
        check("pre_rst_wr_en", wr_en, 1);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_outs", {wr_en, wr_bank, rd_bank, frame_done, err_oob, err_short}, 6'b001000);
        check("async_rst_addr_data", {wr_addr, wr_data}, 0);
        check("async_rst_tready", pixel_axis_tready, 0);
        @(negedge aclk);
        rst_in = 1'b0;
        exp_bank = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (wr_en !== 1'b0) stall_bad++;
        end
        check("no_wr_after_rst", stall_bad, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
